// File: rtl/adc_bus_in_if.sv
// adc_bus_in_if: bundle of the interleaved I/Q receive bus.
// master = pin/control side that drives samples, slave = the receiver.
// ERR_W must match the ERR_W of the adc_bus_in instance it connects to.
interface adc_bus_in_if #(
    parameter int ERR_W = 16
);
    logic             adc_sel;
    logic [9:0]       adc_data;
    logic             err_clr;
    logic [7:0]       adc_out_i;
    logic [7:0]       adc_out_q;
    logic             iq_valid;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output adc_sel, adc_data, err_clr,
        input  adc_out_i, adc_out_q, iq_valid, locked, err_cnt
    );

    modport slave (
        input  adc_sel, adc_data, err_clr,
        output adc_out_i, adc_out_q, iq_valid, locked, err_cnt
    );
endinterface

// File: rtl/adc_bus_in.sv
// adc_bus_in: receive side of the interleaved I/Q converter bus.
// Registers the 10-bit multiplexed ADC bus, pairs I->Q samples into 8-bit
// words, tracks phase lock on the sel alternation and counts violations.
// Optional build macro ADC_ROUND_EN: round-half-up with saturation instead
// of plain truncation when reducing 10-bit samples to 8 bits.
//
// Output protocol: iq_valid is a one-cycle strobe with no backpressure;
// adc_out_i/adc_out_q are valid in the cycle iq_valid is high and hold
// their value until the next strobe. The consumer must take every strobe.
module adc_bus_in #(
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic         clk_in,
    input  logic         rst_in,
    adc_bus_in_if.slave  bus,
    output logic [1:0]   fsm_state
);

    typedef enum logic [1:0] {
        HUNT_I = 2'd0,
        HUNT_Q = 2'd1,
        LOCK_I = 2'd2,
        LOCK_Q = 2'd3
    } state_t;

    state_t           state, state_n;
    logic             sel_r;
    logic [9:0]       data_r;
    logic [3:0]       cnt, cnt_n;
    logic [7:0]       held_i, held_n;
    logic [7:0]       out_i, out_i_n;
    logic [7:0]       out_q, out_q_n;
    logic             valid, valid_n;
    logic             locked_r, locked_n;
    logic [ERR_W-1:0] err, err_n;
    logic             viol;
    logic [7:0]       data_cv;

`ifdef ADC_ROUND_EN
    logic [8:0] rnd;

    // Round half up, then clamp the one overflow code (256) to full scale.
    always_comb begin
        rnd     = 9'(({1'b0, data_r} + 11'd2) >> 2);
        data_cv = rnd[8] ? 8'hFF : rnd[7:0];
    end
`else
    // Plain truncation: keep the top eight bits.
    always_comb begin
        data_cv = 8'(data_r >> 2);
    end
`endif

    // Stage-1 capture of the pins plus all FSM and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sel_r    <= 1'b0;
            data_r   <= '0;
            state    <= HUNT_I;
            cnt      <= '0;
            held_i   <= '0;
            out_i    <= '0;
            out_q    <= '0;
            valid    <= 1'b0;
            locked_r <= 1'b0;
            err      <= '0;
        end else begin
            sel_r    <= bus.adc_sel;
            data_r   <= bus.adc_data;
            state    <= state_n;
            cnt      <= cnt_n;
            held_i   <= held_n;
            out_i    <= out_i_n;
            out_q    <= out_q_n;
            valid    <= valid_n;
            locked_r <= locked_n;
            err      <= err_n;
        end
    end

    // Next-state: hunt for LOCK_CNT clean I->Q pairs, then deliver pairs
    // until the alternation breaks.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        held_n   = held_i;
        out_i_n  = out_i;
        out_q_n  = out_q;
        valid_n  = 1'b0;
        locked_n = locked_r;
        viol     = 1'b0;
        err_n    = err;

        case (state)
            HUNT_I: begin
                if (sel_r) begin
                    held_n  = data_cv;
                    state_n = HUNT_Q;
                end else begin
                    cnt_n = '0;
                end
            end
            HUNT_Q: begin
                if (!sel_r) begin
                    cnt_n = cnt + 4'd1;
                    if (cnt + 4'd1 == 4'(LOCK_CNT)) begin
                        // Lock-completing pair is consumed without a strobe.
                        state_n  = LOCK_I;
                        locked_n = 1'b1;
                    end else begin
                        state_n = HUNT_I;
                    end
                end else begin
                    // Repeated I while hunting restarts the run on the new I.
                    held_n = data_cv;
                    cnt_n  = '0;
                end
            end
            LOCK_I: begin
                if (sel_r) begin
                    held_n  = data_cv;
                    state_n = LOCK_Q;
                end else begin
                    viol = 1'b1;
                end
            end
            LOCK_Q: begin
                if (!sel_r) begin
                    out_i_n = held_i;
                    out_q_n = data_cv;
                    valid_n = 1'b1;
                    state_n = LOCK_I;
                end else begin
                    viol = 1'b1;
                end
            end
            default: begin
                state_n = HUNT_I;
            end
        endcase

        // A violating I sample is kept as the start of a fresh pair.
        if (viol) begin
            locked_n = 1'b0;
            cnt_n    = '0;
            if (sel_r) begin
                held_n  = data_cv;
                state_n = HUNT_Q;
            end else begin
                state_n = HUNT_I;
            end
        end

        // Clear beats a same-edge violation; count saturates at all-ones.
        if (bus.err_clr) begin
            err_n = '0;
        end else if (viol && (err != '1)) begin
            err_n = err + 1'b1;
        end
    end

    assign bus.adc_out_i = out_i;
    assign bus.adc_out_q = out_q;
    assign bus.iq_valid  = valid;
    assign bus.locked    = locked_r;
    assign bus.err_cnt   = err;
    assign fsm_state     = state;

endmodule

// File: tb/tb_adc_bus_in.sv
// tb_adc_bus_in: randomized bench for adc_bus_in with a sample-level model.
// Two instances run on the same stimulus: ERR_W=16 and ERR_W=2 (saturation).
`timescale 1ns/1ps
module tb_adc_bus_in;

    localparam int LOCK_CNT = 4;

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    adc_bus_in_if #(.ERR_W(16)) bus_a ();
    adc_bus_in_if #(.ERR_W(2))  bus_b ();
    logic [1:0] st_a, st_b;

    adc_bus_in #(.LOCK_CNT(LOCK_CNT), .ERR_W(16)) dut_a (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bus_a), .fsm_state(st_a));
    adc_bus_in #(.LOCK_CNT(LOCK_CNT), .ERR_W(2)) dut_b (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bus_b), .fsm_state(st_b));

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;
    logic prev_v = 1'b0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the sample stream as "pending I / good-pair run / locked".
    logic       m_sel_r = 1'b0;
    int         m_data_r = 0;
    logic       m_have_i = 1'b0;
    int         m_i_val = 0;
    int         m_run = 0;
    logic       m_locked = 1'b0;
    int         m_err_a = 0;
    int         m_err_b = 0;
    int         m_out_i = 0;
    int         m_out_q = 0;
    logic       m_v = 1'b0;

    function automatic int conv(input int raw);
`ifdef ADC_ROUND_EN
        int v;
        v = (raw + 2) / 4;
        if (v > 255) v = 255;
        return v;
`else
        return raw / 4;
`endif
    endfunction

    task automatic model_edge(input logic sel, input logic [9:0] data,
                              input logic clr, input logic rst);
        int d;
        logic s;
        logic viol;
        if (rst) begin
            m_sel_r = 0; m_data_r = 0; m_have_i = 0; m_i_val = 0; m_run = 0;
            m_locked = 0; m_err_a = 0; m_err_b = 0; m_out_i = 0; m_out_q = 0;
            m_v = 0;
            return;
        end
        m_v  = 0;
        viol = 0;
        s    = m_sel_r;
        d    = conv(m_data_r);
        if (m_locked) begin
            if (m_have_i && !s) begin
                m_out_i = m_i_val;
                m_out_q = d;
                m_v = 1;
                m_have_i = 0;
                exp_q.push_back({m_i_val[7:0], d[7:0]});
            end else if (m_have_i == s) begin
                viol = 1;
            end else begin
                m_have_i = 1;
                m_i_val = d;
            end
            if (viol) begin
                m_locked = 0;
                m_run = 0;
                m_have_i = s;
                if (s) m_i_val = d;
                if (m_err_a < 65535) m_err_a++;
                if (m_err_b < 3) m_err_b++;
            end
        end else begin
            if (s) begin
                if (m_have_i) m_run = 0;
                m_have_i = 1;
                m_i_val = d;
            end else if (m_have_i) begin
                m_have_i = 0;
                m_run++;
                if (m_run == LOCK_CNT) m_locked = 1;
            end else begin
                m_run = 0;
            end
        end
        if (clr) begin
            m_err_a = 0;
            m_err_b = 0;
        end
        m_sel_r  = sel;
        m_data_r = int'(data);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic sel, input logic [9:0] data,
                        input logic clr = 1'b0, input logic rst = 1'b0);
        bus_a.adc_sel = sel; bus_a.adc_data = data; bus_a.err_clr = clr;
        bus_b.adc_sel = sel; bus_b.adc_data = data; bus_b.err_clr = clr;
        rst_in = rst;
        @(posedge clk_in);
        model_edge(sel, data, clr, rst);
        @(negedge clk_in);
    endtask

    task automatic send_pair(input logic [9:0] i_val, input logic [9:0] q_val);
        step(1'b1, i_val);
        step(1'b0, q_val);
    endtask

    task automatic rnd_pairs(input int n);
        for (int k = 0; k < n; k++)
            send_pair(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk_in) begin
        if (cmp_en) begin
            check("a_iq_valid", {31'd0, bus_a.iq_valid}, {31'd0, m_v});
            check("a_out_i", {24'd0, bus_a.adc_out_i}, m_out_i);
            check("a_out_q", {24'd0, bus_a.adc_out_q}, m_out_q);
            check("a_locked", {31'd0, bus_a.locked}, {31'd0, m_locked});
            check("a_err_cnt", {16'd0, bus_a.err_cnt}, m_err_a);
            check("b_iq_valid", {31'd0, bus_b.iq_valid}, {31'd0, m_v});
            check("b_locked", {31'd0, bus_b.locked}, {31'd0, m_locked});
            check("b_err_cnt", {30'd0, bus_b.err_cnt}, m_err_b);
            check("valid_not_back_to_back", {31'd0, bus_a.iq_valid & prev_v}, 32'd0);
            if (bus_a.iq_valid) begin
                check("pair_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("pair_data", {16'd0, bus_a.adc_out_i, bus_a.adc_out_q}, {16'd0, e});
                end
            end
            prev_v = bus_a.iq_valid;
        end
    end

    // ---------------- stimulus ----------------
`ifdef ADC_ROUND_EN
    localparam logic [7:0] EXP_Q0 = 8'h57;
`else
    localparam logic [7:0] EXP_Q0 = 8'h56;
`endif

    initial begin
        logic alt;
        logic [9:0] x;

        // Reset and pattern lock-in with fixed samples.
        step(1'b0, 10'd0, 1'b0, 1'b1);
        step(1'b0, 10'd0, 1'b0, 1'b1);
        cmp_en = 1'b1;
        #1;
        check("rst_locked", {31'd0, bus_a.locked}, 32'd0);
        check("rst_err", {16'd0, bus_a.err_cnt}, 32'd0);
        check("rst_out_i", {24'd0, bus_a.adc_out_i}, 32'd0);
        for (int p = 0; p < 4; p++) send_pair(10'h2A5, 10'h15A);
        #1 check("lock_not_yet", {31'd0, bus_a.locked}, 32'd0);
        step(1'b1, 10'h2A5);
        #1 check("lock_rise", {31'd0, bus_a.locked}, 32'd1);
        check("lock_pair_no_strobe", {31'd0, bus_a.iq_valid}, 32'd0);
        step(1'b0, 10'h15A);
        #1 check("no_strobe_on_i", {31'd0, bus_a.iq_valid}, 32'd0);
        step(1'b1, 10'h2A5);
        #1 check("first_strobe", {31'd0, bus_a.iq_valid}, 32'd1);
        check("first_out_i", {24'd0, bus_a.adc_out_i}, 32'hA9);
        check("first_out_q", {24'd0, bus_a.adc_out_q}, {24'd0, EXP_Q0});
        step(1'b0, 10'h15A);
        rnd_pairs(12);

        // Double Q while locked.
        step(1'b0, 10'($urandom_range(0, 1023)));
        step(1'b1, 10'h100);
        #1 check("dq_unlock", {31'd0, bus_a.locked}, 32'd0);
        check("dq_err", {16'd0, bus_a.err_cnt}, 32'd1);
        check("dq_no_strobe", {31'd0, bus_a.iq_valid}, 32'd0);
        step(1'b0, 10'h200);
        rnd_pairs(6);

        // Double I while locked: second I starts the relock run.
        step(1'b1, 10'h111);
        step(1'b1, 10'h222);
        step(1'b0, 10'h333);
        #1 check("di_unlock", {31'd0, bus_a.locked}, 32'd0);
        check("di_err", {16'd0, bus_a.err_cnt}, 32'd2);
        rnd_pairs(3);
        #1 check("di_not_yet", {31'd0, bus_a.locked}, 32'd0);

        // Full-scale samples saturate in both builds.
        step(1'b1, 10'h3FE);
        #1 check("di_relock", {31'd0, bus_a.locked}, 32'd1);
        step(1'b0, 10'h3FD);
        step(1'b1, 10'h3FE);
        #1 check("sat_strobe", {31'd0, bus_a.iq_valid}, 32'd1);
        check("sat_out_i", {24'd0, bus_a.adc_out_i}, 32'hFF);
        check("sat_out_q", {24'd0, bus_a.adc_out_q}, 32'hFF);
        step(1'b0, 10'h3FD);

        // Five counted violations, then clear on a violation edge.
        step(1'b0, 10'd0, 1'b0, 1'b1);
        for (int v = 0; v < 5; v++) begin
            rnd_pairs(5);
            step(1'b0, 10'($urandom_range(0, 1023)));
        end
        step(1'b1, 10'h155);
        #1 check("sat_err_a", {16'd0, bus_a.err_cnt}, 32'd5);
        check("sat_err_b", {30'd0, bus_b.err_cnt}, 32'd3);
        step(1'b0, 10'h0AA);
        rnd_pairs(5);
        step(1'b0, 10'h012);
        step(1'b1, 10'h155, 1'b1);
        #1 check("clr_wins_a", {16'd0, bus_a.err_cnt}, 32'd0);
        check("clr_wins_b", {30'd0, bus_b.err_cnt}, 32'd0);
        check("clr_unlock", {31'd0, bus_a.locked}, 32'd0);
        step(1'b0, 10'h0AA);

        // Reset between an I and its Q while locked.
        rnd_pairs(6);
        step(1'b1, 10'h2F0);
        step(1'b0, 10'h1F0, 1'b0, 1'b1);
        #1 check("midrst_valid", {31'd0, bus_a.iq_valid}, 32'd0);
        check("midrst_out_q", {24'd0, bus_a.adc_out_q}, 32'd0);
        check("midrst_locked", {31'd0, bus_a.locked}, 32'd0);
        rnd_pairs(6);

        // Constant sel=0 after reset never locks.
        step(1'b0, 10'd0, 1'b0, 1'b1);
        for (int c = 0; c < 20; c++) step(1'b0, 10'($urandom_range(0, 1023)));
        #1 check("q_only_locked", {31'd0, bus_a.locked}, 32'd0);
        check("q_only_err", {16'd0, bus_a.err_cnt}, 32'd0);

        // Random stream: mostly alternating, with slips, clears and resets.
        alt = 1'b1;
        for (int c = 0; c < 400; c++) begin
            x = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 11) == 0) alt = ~alt;
            step(alt, x, 1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 199) == 0));
            alt = ~alt;
        end
        step(1'b0, 10'd0);
        step(1'b0, 10'd0);
        #1 check("queue_drained", exp_q.size(), 32'd0);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
